pixel_shade_writer: RTL
=======================

Name: pixel_shade_writer

Overview:
- Consumes per-pixel intersection results from the block selector stage: pixel XY, best block index and float hit distance t.
- Converts each result into a 12-bit RGB444 colour using a per-block palette and integer depth shading.
- Computes the linear framebuffer address and buffers (address, colour) words in a small FIFO.
- Drains the FIFO to the framebuffer write port with a valid/ready handshake. The upstream pipeline cannot stall, so words that arrive while the FIFO is full are dropped and counted.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels; x >= FB_WIDTH is discarded
FB_HEIGHT, 180, framebuffer height in pixels; y >= FB_HEIGHT is discarded
ADDR_W, 16, framebuffer address width; must satisfy FB_WIDTH*FB_HEIGHT <= 2**ADDR_W
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4
NEAR_EXP, 8'd130, float exponent field at or below which no depth darkening is applied

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
x_in  input  11  pixel x from block selector
y_in  input  10  pixel y from block selector
best_block_in  input  4  hit block index; 15 = no hit
best_t_in  input  32  IEEE-754 single-precision hit distance
valid_in  input  1  one-cycle strobe qualifying the inputs above; no backpressure
fb_addr_out  output  ADDR_W  framebuffer write address
fb_data_out  output  12  RGB444 colour, {r[3:0], g[3:0], b[3:0]}
fb_sof_out  output  1  word is pixel (0,0), marking start of frame
fb_valid_out  output  1  FIFO head is valid
fb_ready_in  input  1  framebuffer accepts the word this cycle
drop_count_out  output  16  saturating count of dropped words
overflow_out  output  1  sticky; set on the first drop

Behaviour:
- Reset: asynchronous and active-low. All outputs and all state go to 0, the FIFO empties, and the pipeline valid bits clear. An in-flight word is lost, with no drop counted. Outputs are registered, so no output glitches while reset releases.
- Stage A (cycle 1): register the inputs when valid_in = 1; the valid bit follows valid_in.
- Stage B (cycle 2) computes the following from the stage-A registers:
  - Background: best_block = 15, or best_block > 11, or t sign bit = 1 gives colour = BG_COLOR with no shading.
  - Otherwise, base = PALETTE[best_block]; e = t[30:23]; s = (e <= NEAR_EXP) ? 0 : min(e - NEAR_EXP, 7).
  - Each channel c' = (c > s) ? c - s : 0, using 4-bit unsigned arithmetic and no wrap.
  - addr = y*FB_WIDTH + x, truncated to ADDR_W. The multiply is a constant multiply in one cycle.
  - Out-of-range: x >= FB_WIDTH or y >= FB_HEIGHT discards the word silently. It does not count as a drop.
  - sof = (x == 0 && y == 0).
- Push: at the end of stage B a valid in-range word is pushed into the FIFO. Latency from valid_in to FIFO write is 2 cycles; fb_valid_out rises on cycle 3 when the FIFO was empty.
- FIFO: show-ahead, so fb_addr_out, fb_data_out and fb_sof_out present the head entry whenever fb_valid_out = 1.
  - Pop occurs when fb_valid_out && fb_ready_in.
  - Outputs hold stable while fb_valid_out = 1 and fb_ready_in = 0.
  - Word storage is FIFO_DEPTH x (ADDR_W + 13). Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty are derived from pointer comparison.
- Boundary conditions:
  - Push when full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Push when full with no pop: the word is dropped. drop_count_out increments and saturates at 16'hFFFF. overflow_out sets and stays set until reset.
  - Push and pop on an empty FIFO: the word is not bypassed. It appears on the next cycle.
  - Pointer wrap-around must be seamless across repeated fills.
- Throughput: one word per cycle sustained when fb_ready_in is held at 1.

Decomposition:
- Package pixel_shade_pkg holds:
  - typedef rgb444_t, a packed struct {r, g, b} of 4 bits each;
  - localparam NO_HIT_BLOCK = 4'd15;
  - localparam NUM_BLOCKS = 12;
  - localparam BG_COLOR = 12'h000;
  - localparam rgb444_t PALETTE[12], with distinct non-zero entries;
  - function shade(rgb444_t, logic [7:0] exp).
- One sub-module: shade_fifo, a parameterised synchronous show-ahead FIFO with push/pop/full/empty and async active-low reset.

Test Plan:
- Reset value: assert rst_n_in low mid-stream with the FIFO holding 5 words -> all outputs 0 immediately, without waiting for a clock edge; after release fb_valid_out stays 0 until a new input arrives.
- Hit shading:
  - x=3, y=2, block=1, t=0x41200000 (e=130) -> addr=643, data=PALETTE[1] unshaded, fb_valid_out on cycle 3.
  - t=0x42C80000 (e=133) -> each channel reduced by 3 with floor 0.
- No hit and discard:
  - block=15 at x=0, y=0 -> data=BG_COLOR, addr=0, sof=1.
  - x=320, y=5 -> no word emitted and drop_count_out stays 0.
- Backpressure: fb_ready_in=0 while 16 pixels stream in -> 16 words held with stable outputs. Pixel 17 is dropped: drop_count_out=1 and overflow_out=1. Then fb_ready_in=1 -> the 16 words drain in order.
- Full with simultaneous pop: fill to 16, then push with fb_ready_in=1 in the same cycle -> the push is accepted, no drop, and the count stays at 16.
- Wrap and throughput: stream 100 pixels back-to-back with fb_ready_in=1 -> 100 words in order with correct addresses, no bubbles after the first, and no drops.

Source files
------------

// File: rtl/pixel_shade_pkg.sv
// Shared types, palette and shading helpers for the pixel shade writer.
// The palette maps block indices 0..11 to base RGB444 colours.
package pixel_shade_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam logic [3:0]  NO_HIT_BLOCK = 4'd15;
    localparam int          NUM_BLOCKS   = 12;
    localparam logic [11:0] BG_COLOR     = 12'h000;

    localparam rgb444_t PALETTE [NUM_BLOCKS] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'h842,
        12'h2A5, 12'hC63, 12'h5BE, 12'h9D1
    };

    function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] s);
        logic [3:0] res;
        if (a > s) begin
            res = a - s;
        end else begin
            res = 4'd0;
        end
        return res;
    endfunction

    // Darken by one step per exponent above the near plane, at most seven steps.
    function automatic rgb444_t shade(input rgb444_t c, input logic [7:0] exp,
                                      input logic [7:0] near_exp = 8'd130);
        logic [7:0] diff;
        logic [3:0] s;
        rgb444_t    res;
        diff = exp - near_exp;
        if (exp <= near_exp) begin
            s = 4'd0;
        end else if (diff > 8'd7) begin
            s = 4'd7;
        end else begin
            s = diff[3:0];
        end
        res.r = sat_sub4(c.r, s);
        res.g = sat_sub4(c.g, s);
        res.b = sat_sub4(c.b, s);
        return res;
    endfunction

    function automatic rgb444_t palette_at(input logic [3:0] idx);
        rgb444_t res;
        case (idx)
            4'd0:    res = PALETTE[0];
            4'd1:    res = PALETTE[1];
            4'd2:    res = PALETTE[2];
            4'd3:    res = PALETTE[3];
            4'd4:    res = PALETTE[4];
            4'd5:    res = PALETTE[5];
            4'd6:    res = PALETTE[6];
            4'd7:    res = PALETTE[7];
            4'd8:    res = PALETTE[8];
            4'd9:    res = PALETTE[9];
            4'd10:   res = PALETTE[10];
            4'd11:   res = PALETTE[11];
            default: res = BG_COLOR;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shade_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; storage resets to zero
// so the head reads as zero while in reset.
module shade_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop_s  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = mem_q[rd_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Word storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/pixel_shade_writer.sv
// Turns block-selector hit results into shaded RGB444 framebuffer writes,
// buffered in a FIFO; words arriving while it is full are dropped and counted.
module pixel_shade_writer
    import pixel_shade_pkg::*;
#(
    parameter int         FB_WIDTH   = 320,
    parameter int         FB_HEIGHT  = 180,
    parameter int         ADDR_W     = 16,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] NEAR_EXP   = 8'd130
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    input  logic [3:0]        best_block_in,
    input  logic [31:0]       best_t_in,
    input  logic              valid_in,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [11:0]       fb_data_out,
    output logic              fb_sof_out,
    output logic              fb_valid_out,
    input  logic              fb_ready_in,
    output logic [15:0]       drop_count_out,
    output logic              overflow_out
);

    localparam int WORD_W = ADDR_W + 13;

    logic              valid_a_q;
    logic [10:0]       x_a_q;
    logic [9:0]        y_a_q;
    logic [3:0]        blk_a_q;
    logic              sign_a_q;
    logic [7:0]        exp_a_q;

    logic              in_range_s;
    logic              bg_s;
    logic [ADDR_W-1:0] addr_b_s;
    rgb444_t           color_b_s;
    logic              sof_b_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic              drop_s;
    logic [WORD_W-1:0] word_in_s;
    logic [WORD_W-1:0] word_out_s;

    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    // Only sign and exponent of the hit distance drive the shading.
    logic              unused_mant_s;
    assign unused_mant_s = ^best_t_in[22:0];

    // Stage A: capture qualified inputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_a_q <= 1'b0;
            x_a_q     <= 11'd0;
            y_a_q     <= 10'd0;
            blk_a_q   <= 4'd0;
            sign_a_q  <= 1'b0;
            exp_a_q   <= 8'd0;
        end else begin
            valid_a_q <= valid_in;
            if (valid_in) begin
                x_a_q    <= x_in;
                y_a_q    <= y_in;
                blk_a_q  <= best_block_in;
                sign_a_q <= best_t_in[31];
                exp_a_q  <= best_t_in[30:23];
            end else begin
                x_a_q    <= x_a_q;
                y_a_q    <= y_a_q;
                blk_a_q  <= blk_a_q;
                sign_a_q <= sign_a_q;
                exp_a_q  <= exp_a_q;
            end
        end
    end

    // Stage B: colour, address and range check, feeding the FIFO write.
    always_comb begin
        bg_s       = (blk_a_q == NO_HIT_BLOCK) || (blk_a_q > 4'd11) || sign_a_q;
        in_range_s = (32'(x_a_q) < FB_WIDTH) && (32'(y_a_q) < FB_HEIGHT);
        addr_b_s   = ADDR_W'(y_a_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(x_a_q);
        sof_b_s    = (x_a_q == 11'd0) && (y_a_q == 10'd0);
        if (bg_s) begin
            color_b_s = BG_COLOR;
        end else begin
            color_b_s = shade(palette_at(blk_a_q), exp_a_q, NEAR_EXP);
        end
    end

    assign push_s    = valid_a_q && in_range_s;
    assign pop_s     = !empty_s && fb_ready_in;
    assign drop_s    = push_s && full_s && !pop_s;
    assign word_in_s = {sof_b_s, addr_b_s, color_b_s};

    shade_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .push_i  (push_s),
        .data_i  (word_in_s),
        .pop_i   (pop_s),
        .data_o  (word_out_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign fb_valid_out = !empty_s;
    assign fb_sof_out   = word_out_s[WORD_W-1];
    assign fb_addr_out  = word_out_s[WORD_W-2:12];
    assign fb_data_out  = word_out_s[11:0];

    // Drop accounting next-state; the counter saturates rather than wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            drop_cnt_d = drop_cnt_q;
            overflow_d = overflow_q;
        end
    end

    // Drop accounting registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign drop_count_out = drop_cnt_q;
    assign overflow_out   = overflow_q;

endmodule
